// File: rtl/unidade_muldiv.sv
// Iterative RV64M multiply/divide unit: one radix-2 step per cycle, single outstanding operation.
// Multiply is shift-add on magnitudes; divide is restoring shift-subtract; signs fixed up in StFim.
module unidade_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iniciar,
  input  logic            cancelar,
  input  logic [2:0]      funct3,
  input  logic            op_w,
  input  logic [XLEN-1:0] operando_a,
  input  logic [XLEN-1:0] operando_b,
  input  logic [4:0]      endereco_regd,
  output logic            ocupado,
  output logic            pronto,
  output logic [XLEN-1:0] resultado,
  output logic [4:0]      endereco_regd_saida
);

  typedef enum logic [1:0] {StIdle, StCalc, StFim} state_e;

  state_e              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                op_w_q, op_w_d;
  logic                neg_q, neg_d;
  logic                neg_a_q, neg_a_d;
  logic [4:0]          rd_q, rd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     dvd_q, dvd_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic [XLEN-1:0]     resultado_q, resultado_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic                pronto_q, pronto_d;

  // Capture-time decode; illegal word MULH* variants collapse onto MULW.
  logic [2:0]      f3_in;
  logic            sa, sb, neg_a_in, neg_b_in;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;

  assign f3_in    = (op_w && !funct3[2]) ? 3'b000 : funct3;
  assign sa       = f3_in[2] ? ~f3_in[0] : (f3_in == 3'b001 || f3_in == 3'b010);
  assign sb       = f3_in[2] ? ~f3_in[0] : (f3_in == 3'b001);
  assign a_ext    = op_w ? {{(XLEN-32){sa & operando_a[31]}}, operando_a[31:0]} : operando_a;
  assign b_ext    = op_w ? {{(XLEN-32){sb & operando_b[31]}}, operando_b[31:0]} : operando_b;
  assign neg_a_in = sa & a_ext[XLEN-1];
  assign neg_b_in = sb & b_ext[XLEN-1];
  assign mag_a    = neg_a_in ? -a_ext : a_ext;
  assign mag_b    = neg_b_in ? -b_ext : b_ext;

  // Restoring divide step; the 65-bit trial covers divisors above 2^63.
  logic [XLEN:0] trial, trial_sub;
  logic          sub_ok;

  assign trial     = {rem_q, dvd_q[XLEN-1]};
  assign sub_ok    = trial >= {1'b0, divisor_q};
  assign trial_sub = trial - {1'b0, divisor_q};

  // Divide by zero leaves rem_q equal to the dividend magnitude, so only the quotient
  // needs overriding; most-negative / -1 falls out of the magnitude arithmetic.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, base, fim_res;

  always_comb begin
    prod_s = neg_q ? -prod_q : prod_q;
    quo_s  = (divisor_q == '0) ? '1 : (neg_q ? -dvd_q : dvd_q);
    rem_s  = neg_a_q ? -rem_q : rem_q;
    if (f3_q[2]) begin
      base = f3_q[1] ? rem_s : quo_s;
    end else if (op_w_q || f3_q == 3'b000) begin
      base = prod_s[XLEN-1:0];
    end else begin
      base = prod_s[2*XLEN-1:XLEN];
    end
    fim_res = op_w_q ? {{(XLEN-32){base[31]}}, base[31:0]} : base;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    op_w_d      = op_w_q;
    neg_d       = neg_q;
    neg_a_d     = neg_a_q;
    rd_d        = rd_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    divisor_d   = divisor_q;
    resultado_d = resultado_q;
    rd_out_d    = rd_out_q;
    pronto_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iniciar && !cancelar) begin
          state_d   = StCalc;
          cnt_d     = op_w ? 7'(XLEN / 2) : 7'(XLEN);
          f3_d      = f3_in;
          op_w_d    = op_w;
          neg_d     = neg_a_in ^ neg_b_in;
          neg_a_d   = neg_a_in;
          rd_d      = endereco_regd;
          prod_d    = '0;
          mcand_d   = {{XLEN{1'b0}}, mag_a};
          mplier_d  = mag_b;
          rem_d     = '0;
          // Word dividends are left-aligned so the MSB-first shift is width independent.
          dvd_d     = op_w ? {mag_a[31:0], 32'h0} : mag_a;
          divisor_d = mag_b;
        end
      end
      StCalc: begin
        if (cancelar) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          rem_d    = sub_ok ? trial_sub[XLEN-1:0] : trial[XLEN-1:0];
          dvd_d    = {dvd_q[XLEN-2:0], sub_ok};
          cnt_d    = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = StFim;
        end
      end
      StFim: begin
        state_d = StIdle;
        if (!cancelar) begin
          pronto_d    = 1'b1;
          resultado_d = fim_res;
          rd_out_d    = rd_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      f3_q        <= '0;
      op_w_q      <= 1'b0;
      neg_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      rd_q        <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      divisor_q   <= '0;
      resultado_q <= '0;
      rd_out_q    <= '0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      op_w_q      <= op_w_d;
      neg_q       <= neg_d;
      neg_a_q     <= neg_a_d;
      rd_q        <= rd_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      divisor_q   <= divisor_d;
      resultado_q <= resultado_d;
      rd_out_q    <= rd_out_d;
      pronto_q    <= pronto_d;
    end
  end

  assign ocupado             = (state_q != StIdle);
  assign pronto              = pronto_q;
  assign resultado           = resultado_q;
  assign endereco_regd_saida = rd_out_q;

endmodule

// File: tb/tb_unidade_muldiv.sv
// Scoreboard bench for unidade_muldiv: the driver queues hand-computed results at each accept,
// a monitor pops and checks value, index, latency and busy time whenever pronto is seen.
module tb_unidade_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iniciar = 1'b0;
  logic        cancelar = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        op_w = 1'b0;
  logic [63:0] operando_a = '0;
  logic [63:0] operando_b = '0;
  logic [4:0]  endereco_regd = '0;
  logic        ocupado;
  logic        pronto;
  logic [63:0] resultado;
  logic [4:0]  endereco_regd_saida;

  unidade_muldiv #(.XLEN(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .iniciar             (iniciar),
    .cancelar            (cancelar),
    .funct3              (funct3),
    .op_w                (op_w),
    .operando_a          (operando_a),
    .operando_b          (operando_b),
    .endereco_regd       (endereco_regd),
    .ocupado             (ocupado),
    .pronto              (pronto),
    .resultado           (resultado),
    .endereco_regd_saida (endereco_regd_saida)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int unsigned lat;
    int unsigned acc_cyc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [63:0] last_res = '0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin : monitor
    int unsigned busy;
    logic        prev_busy;
    exp_t        e;
    busy = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ocupado) busy = prev_busy ? busy + 1 : 1;
      prev_busy = ocupado;
      if (pronto === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL spurious_pronto: pronto=1 with resultado %h but nothing pending", resultado);
        end else begin
          e = sb_q.pop_front();
          check64({e.name, " resultado"}, resultado, e.res);
          check64({e.name, " rd"}, 64'(endereco_regd_saida), 64'(e.rd));
          check64({e.name, " latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
          check64({e.name, " busy cycles"}, 64'(busy), 64'(e.lat));
        end
      end
    end
  end

  // Called just after a negedge; returns 1ns after the accept edge.
  task automatic start(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input string name,
                       input logic [63:0] exp_res, input bit push);
    funct3 = f;
    op_w = w;
    operando_a = a;
    operando_b = b;
    endereco_regd = rd;
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      sb_q.push_back('{res: exp_res, rd: rd, lat: (w ? 33 : 65), acc_cyc: cyc, name: name});
      last_res = exp_res;
    end
    iniciar = 1'b0;
    operando_a = ~a;
    operando_b = ~b;
    endereco_regd = ~rd;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!ocupado && sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s timeout: ocupado=%b pending=%0d after 300 cycles", name, ocupado,
               sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd, input string name,
                     input logic [63:0] exp_res);
    @(negedge clk);
    start(f, w, a, b, rd, name, exp_res, 1'b1);
    wait_idle(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    repeat (3) @(negedge clk);
    check64("reset ocupado", 64'(ocupado), 64'd0);
    check64("reset pronto", 64'(pronto), 64'd0);
    check64("reset resultado", resultado, 64'd0);
    check64("reset rd", 64'(endereco_regd_saida), 64'd0);
    rst_n = 1'b1;

    run(3'b000, 1'b0, 64'd7, 64'd6, 5'd5, "mul 7x6", 64'h2A);
    run(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, "mulh", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, "mulhu", 64'h1);
    run(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, "mulhsu", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, "div -7/2", 64'hFFFF_FFFF_FFFF_FFFD);
    run(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, "rem -7/2", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b101, 1'b0, 64'd100, 64'd7, 5'd8, "divu 100/7", 64'd14);
    run(3'b111, 1'b0, 64'd100, 64'd7, 5'd0, "remu 100/7", 64'd2);
    run(3'b100, 1'b0, 64'd5, 64'd0, 5'd14, "div 5/0", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd15, "div -5/0", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b111, 1'b0, 64'd5, 64'd0, 5'd16, "remu 5/0", 64'd5);
    run(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd17, "rem -7/0", 64'hFFFF_FFFF_FFFF_FFF9);
    run(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, "div ovf",
        64'h8000_0000_0000_0000);
    run(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd19, "rem ovf", 64'd0);
    run(3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 5'd20, "divw", 64'hFFFF_FFFF_C000_0000);
    run(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd21, "mulw", 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd22, "divuw", 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b101, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_0000_0007, 5'd23, "divuw hi junk", 64'd14);
    run(3'b011, 1'b1, 64'hF000_0000_0000_0003, 64'd5, 5'd24, "illegal mulhuw", 64'd15);

    // Cancel on the 10th CALC cycle, then accept immediately afterwards.
    @(negedge clk);
    start(3'b101, 1'b0, 64'd1000, 64'd3, 5'd9, "cancelled", 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancelar = 1'b1;
    @(posedge clk);
    #1;
    check64("cancel ocupado", 64'(ocupado), 64'd0);
    check64("cancel resultado held", resultado, last_res);
    cancelar = 1'b0;
    @(negedge clk);
    start(3'b111, 1'b0, 64'd100, 64'd7, 5'd10, "after cancel", 64'd2, 1'b1);
    check64("accept after cancel", 64'(ocupado), 64'd1);
    wait_idle("after cancel");

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start(3'b000, 1'b0, 64'd3, 64'd3, 5'd7, "reset victim", 64'd0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check64("midreset ocupado", 64'(ocupado), 64'd0);
    check64("midreset pronto", 64'(pronto), 64'd0);
    check64("midreset resultado", resultado, 64'd0);
    check64("midreset rd", 64'(endereco_regd_saida), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // iniciar while busy must be ignored.
    @(negedge clk);
    start(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd11, "div busy", 64'hFFFF_FFFF_FFFF_FFF2,
          1'b1);
    repeat (5) @(negedge clk);
    funct3 = 3'b000;
    operando_a = 64'd1;
    operando_b = 64'd1;
    iniciar = 1'b1;
    repeat (10) @(negedge clk);
    iniciar = 1'b0;
    wait_idle("div busy");

    // Back-to-back: second accept lands on the pronto cycle.
    @(negedge clk);
    start(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd12, "b2b first", 64'd2, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      start(3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, "b2b second",
            64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
    end else begin
      chk_cnt++;
      $display("FAIL b2b pronto: never observed within 200 cycles");
    end
    wait_idle("b2b second");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
